// File: rtl/core_wakeup_pkg.sv
// Shared types and helpers for the core reset-release / interrupt-sync block.
// Holds the FSM encoding, default parameters and delay/width helpers.
package core_wakeup_pkg;

   typedef enum logic [1:0] {
      SRAM_WAIT = 2'd0,
      WAKE_WAIT = 2'd1,
      RUN       = 2'd2,
      SOFT_RST  = 2'd3
   } wake_state_e;

   localparam int unsigned DefNrIrq         = 2;
   localparam int unsigned DefSyncStages    = 2;
   localparam int unsigned DefWakeCntWidth  = 8;
   localparam int unsigned DefWakeMode      = 0;
   localparam int unsigned DefSoftRstCycles = 16;

   // Number of cycles spent in SRAM_WAIT before the core may run.
   function automatic int unsigned wake_delay(input int unsigned wake_cnt_width);
      return 32'd1 << (wake_cnt_width - 1);
   endfunction

   // The single counter serves both the wake delay and the soft-reset hold.
   function automatic int unsigned cnt_width(input int unsigned wake_cnt_width,
                                             input int unsigned soft_rst_cycles);
      int unsigned soft_w;
      soft_w = $clog2(soft_rst_cycles) + 1;
      return (wake_cnt_width > soft_w) ? wake_cnt_width : soft_w;
   endfunction

endpackage

// File: rtl/core_wakeup_sync_sync_stages.sv
// Single-bit synchroniser chain with asynchronous active-high clear to 0.
module sync_stages #(
   parameter int unsigned Depth = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);

   logic [Depth-1:0] chain_d;
   logic [Depth-1:0] chain_q;

   always_comb begin
      chain_d = {chain_q[Depth-2:0], d_i};
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         chain_q <= '0;
      end else begin
         chain_q <= chain_d;
      end
   end

   assign q_o = chain_q[Depth-1];

endmodule

// File: rtl/core_wakeup_sync.sv
// Core reset release after an SRAM-init delay (optionally gated by a wake message),
// software core re-reset, and interrupt synchronisers masked while the core is in reset.
module core_wakeup_sync
   import core_wakeup_pkg::*;
#(
   parameter int unsigned NrIrq         = DefNrIrq,
   parameter int unsigned SyncStages    = DefSyncStages,
   parameter int unsigned WakeCntWidth  = DefWakeCntWidth,
   parameter int unsigned WakeMode      = DefWakeMode,
   parameter int unsigned SoftRstCycles = DefSoftRstCycles
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [NrIrq-1:0] irq_i,
   input  logic             ipi_i,
   input  logic             time_irq_i,
   input  logic             debug_req_i,
   input  logic             wake_i,
   input  logic             soft_rst_req_i,
   output logic             core_rst_no,
   output logic [NrIrq-1:0] irq_o,
   output logic             ipi_o,
   output logic             time_irq_o,
   output logic             debug_req_o,
   output logic [1:0]       state_o
);

   localparam int unsigned CntW      = cnt_width(WakeCntWidth, SoftRstCycles);
   localparam int unsigned WakeDelay = wake_delay(WakeCntWidth);
   localparam logic [CntW-1:0] WakeLast = CntW'(WakeDelay - 1);
   localparam logic [CntW-1:0] SoftLast = CntW'(SoftRstCycles - 1);
   localparam int unsigned NrLines   = NrIrq + 3;

   wake_state_e     state_d, state_q;
   logic [CntW-1:0] cnt_d, cnt_q;
   logic            wake_seen_d, wake_seen_q;
   logic            run;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      wake_seen_d = wake_seen_q | wake_i;
      unique case (state_q)
         SRAM_WAIT: begin
            cnt_d = cnt_q + CntW'(1);
            if (cnt_q == WakeLast) begin
               cnt_d = '0;
               if ((WakeMode == 0) || wake_seen_q) begin
                  state_d = RUN;
               end else begin
                  state_d = WAKE_WAIT;
               end
            end
         end
         WAKE_WAIT: begin
            if (wake_seen_q) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (soft_rst_req_i) begin
               state_d = SOFT_RST;
               cnt_d   = '0;
            end
         end
         SOFT_RST: begin
            cnt_d = cnt_q + CntW'(1);
            if (cnt_q == SoftLast) begin
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         default: begin
            state_d = SRAM_WAIT;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= SRAM_WAIT;
         cnt_q       <= '0;
         wake_seen_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         wake_seen_q <= wake_seen_d;
      end
   end

   assign run     = (state_q == RUN);
   assign state_o = state_q;

   // Core reset: both edges of a soft reset lag the state change by SyncStages.
   sync_stages #(.Depth(SyncStages)) u_run_sync (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .d_i   (run),
      .q_o   (core_rst_no)
   );

   logic [NrLines-1:0] line_in;
   logic [NrLines-1:0] line_sync;

   assign line_in = {debug_req_i, time_irq_i, ipi_i, irq_i};

   for (genvar g = 0; g < NrLines; g++) begin : g_line_sync
      sync_stages #(.Depth(SyncStages)) u_line_sync (
         .clk_i (clk_i),
         .rst_i (rst_i),
         .d_i   (line_in[g]),
         .q_o   (line_sync[g])
      );
   end

   // Interrupts are held low whenever the core itself is held in reset.
   assign irq_o       = line_sync[NrIrq-1:0] & {NrIrq{core_rst_no}};
   assign ipi_o       = line_sync[NrIrq]     & core_rst_no;
   assign time_irq_o  = line_sync[NrIrq+1]   & core_rst_no;
   assign debug_req_o = line_sync[NrIrq+2]   & core_rst_no;

endmodule

// File: tb/tb_core_wakeup_sync.sv
// Directed bench for core_wakeup_sync: default, wake-gated and small/deep-sync variants.
module tb_core_wakeup_sync;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] irq = 2'b00;
   logic       ipi = 1'b0, tim = 1'b0, dbg = 1'b0;
   logic       wake_a = 1'b0, soft_a = 1'b0, wake_b = 1'b0, soft_b = 1'b0;

   logic       core_a, ipi_a, tim_a, dbg_a;
   logic [1:0] irq_a, state_a;
   logic       core_b, ipi_b, tim_b, dbg_b;
   logic [1:0] irq_b, state_b;
   logic       core_c, ipi_c, tim_c, dbg_c;
   logic [1:0] irq_c, state_c;

   int errors = 0;
   int checks = 0;
   int edge_n = 0;

   always #5 clk = ~clk;

   core_wakeup_sync u_dut_a (
      .clk_i(clk), .rst_i(rst), .irq_i(irq), .ipi_i(ipi), .time_irq_i(tim),
      .debug_req_i(dbg), .wake_i(wake_a), .soft_rst_req_i(soft_a),
      .core_rst_no(core_a), .irq_o(irq_a), .ipi_o(ipi_a), .time_irq_o(tim_a),
      .debug_req_o(dbg_a), .state_o(state_a)
   );

   core_wakeup_sync #(.WakeMode(1)) u_dut_b (
      .clk_i(clk), .rst_i(rst), .irq_i(irq), .ipi_i(ipi), .time_irq_i(tim),
      .debug_req_i(dbg), .wake_i(wake_b), .soft_rst_req_i(soft_b),
      .core_rst_no(core_b), .irq_o(irq_b), .ipi_o(ipi_b), .time_irq_o(tim_b),
      .debug_req_o(dbg_b), .state_o(state_b)
   );

   core_wakeup_sync #(.WakeCntWidth(4), .SyncStages(3)) u_dut_c (
      .clk_i(clk), .rst_i(rst), .irq_i(irq), .ipi_i(ipi), .time_irq_i(tim),
      .debug_req_i(dbg), .wake_i(1'b0), .soft_rst_req_i(1'b0),
      .core_rst_no(core_c), .irq_o(irq_c), .ipi_o(ipi_c), .time_irq_o(tim_c),
      .debug_req_o(dbg_c), .state_o(state_c)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s @edge %0d: got %0h expected %0h", tag, edge_n, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      edge_n++;
   endtask

   task automatic release_rst();
      #3 rst = 1'b0;
      edge_n = 0;
   endtask

   // {debug, time, ipi, irq[1:0]} patterns applied while the core runs
   logic [4:0] pat [16] = '{5'b00011, 5'b00001, 5'b00011, 5'b00111, 5'b00011, 5'b01011,
                            5'b01011, 5'b00011, 5'b10011, 5'b10001, 5'b11111, 5'b00000,
                            5'b00010, 5'b10101, 5'b01001, 5'b00011};

   initial begin
      logic [4:0] s1, s2;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_core_a", core_a, 0);
      chk("rst_state_a", state_a, 0);
      chk("rst_irq_a", {dbg_a, tim_a, ipi_a, irq_a}, 0);
      chk("rst_core_c", core_c, 0);

      // Release with irq held high; soft request during SRAM_WAIT must be ignored
      irq = 2'b11;
      release_rst();
      while (edge_n < 131) begin
         wake_b = (edge_n + 1 == 50);
         soft_a = (edge_n + 1 == 20);
         soft_b = soft_a;
         tick();
         if (edge_n == 7)  chk("c_state_pre", state_c, 0);
         if (edge_n == 8)  chk("c_state_run", state_c, 2);
         if (edge_n == 10) chk("c_core_pre", core_c, 0);
         if (edge_n == 11) begin
            chk("c_core_up", core_c, 1);
            chk("c_irq_up", irq_c, 3);
         end
         if (edge_n == 20)  chk("a_soft_ignored", state_a, 0);
         if (edge_n == 127) begin
            chk("a_state_pre", state_a, 0);
            chk("a_core_pre", core_a, 0);
         end
         if (edge_n == 128) begin
            chk("a_state_run", state_a, 2);
            chk("b_state_latched", state_b, 2);
            chk("a_core_128", core_a, 0);
         end
         if (edge_n == 129) begin
            chk("a_core_129", core_a, 0);
            chk("a_irq_masked", irq_a, 0);
         end
         if (edge_n == 130) begin
            chk("a_core_up", core_a, 1);
            chk("a_irq_up", irq_a, 3);
            chk("b_core_up", core_b, 1);
         end
      end
      wake_b = 1'b0; soft_a = 1'b0; soft_b = 1'b0;

      // Interrupt levels against a two-deep reference chain
      s1 = 5'b00011;
      s2 = 5'b00011;
      for (int i = 0; i < 16; i++) begin
         {dbg, tim, ipi, irq} = pat[i];
         tick();
         s2 = s1;
         s1 = pat[i];
         chk("a_irq_model", {dbg_a, tim_a, ipi_a, irq_a}, s2);
         chk("b_irq_model", {dbg_b, tim_b, ipi_b, irq_b}, s2);
      end
      {dbg, tim, ipi, irq} = 5'b00011;
      repeat (3) tick();

      // Soft reset in RUN; B needs no new wake
      soft_a = 1'b1; soft_b = 1'b1;
      tick();
      soft_a = 1'b0; soft_b = 1'b0;
      chk("a_soft_state", state_a, 3);
      chk("b_soft_state", state_b, 3);
      for (int k = 1; k <= 18; k++) begin
         tick();
         if (k == 1) chk("a_soft_core_e1", core_a, 1);
         if (k == 2) begin
            chk("a_soft_core_low", core_a, 0);
            chk("a_soft_irq_low", irq_a, 0);
            chk("b_soft_core_low", core_b, 0);
         end
         if (k == 15) chk("a_soft_hold", state_a, 3);
         if (k == 16) begin
            chk("a_soft_run", state_a, 2);
            chk("b_soft_run", state_b, 2);
         end
         if (k == 17) chk("a_soft_core_e17", core_a, 0);
         if (k == 18) begin
            chk("a_soft_core_up", core_a, 1);
            chk("a_soft_irq_up", irq_a, 3);
            chk("b_soft_core_up", core_b, 1);
         end
      end

      // Async reset mid-SOFT_RST (A) while B and C run
      soft_a = 1'b1;
      tick();
      soft_a = 1'b0;
      repeat (5) tick();
      chk("a_mid_soft", state_a, 3);
      chk("b_run_before", core_b, 1);
      chk("c_irq_before", irq_c, 3);
      #2 rst = 1'b1;
      #1;
      chk("async_state_a", state_a, 0);
      chk("async_core_b", core_b, 0);
      chk("async_irq_b", {dbg_b, tim_b, ipi_b, irq_b}, 0);
      chk("async_core_c", core_c, 0);
      chk("async_irq_c", irq_c, 0);
      @(negedge clk);
      release_rst();

      // Async reset mid-SRAM_WAIT (A, B) with C already running
      repeat (60) tick();
      chk("c_running", core_c, 1);
      chk("a_sram_mid", state_a, 0);
      #2 rst = 1'b1;
      #1;
      chk("async2_core_c", core_c, 0);
      chk("async2_state_c", state_c, 0);
      @(negedge clk);
      release_rst();

      // Full sequence again; B must wait for a fresh wake at edge 300
      while (edge_n < 305) begin
         wake_b = (edge_n + 1 == 300);
         soft_a = (edge_n + 1 == 100);
         soft_b = (edge_n + 1 == 200);
         tick();
         if (edge_n == 11)  chk("c_core_again", core_c, 1);
         if (edge_n == 100) chk("a_soft_sram_ign", state_a, 0);
         if (edge_n == 127) chk("a_state_pre2", state_a, 0);
         if (edge_n == 128) begin
            chk("a_state_run2", state_a, 2);
            chk("b_wake_wait", state_b, 1);
         end
         if (edge_n == 129) chk("a_core_129b", core_a, 0);
         if (edge_n == 130) chk("a_core_up2", core_a, 1);
         if (edge_n == 200) chk("b_soft_ww_ign", state_b, 1);
         if (edge_n == 300) chk("b_ww_300", state_b, 1);
         if (edge_n == 301) chk("b_run_301", state_b, 2);
         if (edge_n == 302) chk("b_core_302", core_b, 0);
         if (edge_n == 303) begin
            chk("b_core_303", core_b, 1);
            chk("b_irq_303", irq_b, 3);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
